// File: rtl/rb_write_bank.sv
// Eight-entry register write bank with a two-state commit/ack handshake.
// Optional macro RB_R0_ZERO_EN hardwires r0 (out0) to zero.
module rb_write_bank #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [2:0]        wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic [DATA_W-1:0] out6,
    output logic [DATA_W-1:0] out7,
    output logic [CNT_W-1:0]  wr_count
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   commit;

    logic [DATA_W-1:0] r [8];

    // State register; reset returns to IDLE and cuts any ack pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a request in IDLE commits; ACK always falls back to IDLE.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_req) begin
                    commit  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register file: only the selected entry loads on a commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < 8; i++) begin
`ifdef RB_R0_ZERO_EN
                if (i != 0 && wr_sel == 3'(i)) begin
                    r[i] <= wr_data;
                end
`else
                if (wr_sel == 3'(i)) begin
                    r[i] <= wr_data;
                end
`endif
            end
        end
    end

    // Commit counter, wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (commit) begin
            wr_count <= wr_count + CNT_W'(1);
        end
    end

    assign wr_ack = (state_q == ACK);

`ifdef RB_R0_ZERO_EN
    assign out0 = '0;
`else
    assign out0 = r[0];
`endif
    assign out1 = r[1];
    assign out2 = r[2];
    assign out3 = r[3];
    assign out4 = r[4];
    assign out5 = r[5];
    assign out6 = r[6];
    assign out7 = r[7];

endmodule

// File: tb/tb_rb_write_bank.sv
// Directed table-driven bench for rb_write_bank.
// Honors RB_R0_ZERO_EN when defined.
module tb_rb_write_bank;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req;
    logic [2:0]    wr_sel;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [DW-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [CW-1:0] wr_count;
    logic [7:0][DW-1:0] outs;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign outs = {o7, o6, o5, o4, o3, o2, o1, o0};

    rb_write_bank #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_sel(wr_sel), .wr_data(wr_data),
        .wr_ack(wr_ack),
        .out0(o0), .out1(o1), .out2(o2), .out3(o3),
        .out4(o4), .out5(o5), .out6(o6), .out7(o7),
        .wr_count(wr_count)
    );

    typedef struct {
        logic               rst;
        logic               req;
        logic [2:0]         sel;
        logic [DW-1:0]      data;
        logic               ack;
        logic [CW-1:0]      cnt;
        logic [7:0][DW-1:0] o;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [7:0][DW-1:0] ov(
        input int a, input logic [DW-1:0] va,
        input int b, input logic [DW-1:0] vb);
        logic [7:0][DW-1:0] t;
        t = '0;
        if (a >= 0) t[a] = va;
        if (b >= 0) t[b] = vb;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic q,
                        input logic [2:0] s, input logic [DW-1:0] d);
        @(negedge clk);
        rst     = r;
        wr_req  = q;
        wr_sel  = s;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acks;
        rst = 1'b1; wr_req = 1'b0; wr_sel = '0; wr_data = '0;

        tbl[0]  = '{1, 0, 0, 16'h0000, 0, 0, ov(-1, 0, -1, 0)};
        tbl[1]  = '{0, 1, 3, 16'h00A5, 1, 1, ov(3, 16'h00A5, -1, 0)};
        tbl[2]  = '{0, 1, 3, 16'h1234, 0, 1, ov(3, 16'h00A5, -1, 0)};
        tbl[3]  = '{0, 0, 3, 16'h0000, 0, 1, ov(3, 16'h00A5, -1, 0)};
        tbl[4]  = '{0, 1, 2, 16'h0011, 1, 2, ov(3, 16'h00A5, 2, 16'h0011)};
        tbl[5]  = '{0, 1, 2, 16'h0022, 0, 2, ov(3, 16'h00A5, 2, 16'h0011)};
        tbl[6]  = '{0, 1, 2, 16'h0033, 1, 3, ov(3, 16'h00A5, 2, 16'h0033)};
        tbl[7]  = '{0, 1, 2, 16'h0044, 0, 3, ov(3, 16'h00A5, 2, 16'h0033)};
        tbl[8]  = '{0, 1, 2, 16'h0055, 1, 4, ov(3, 16'h00A5, 2, 16'h0055)};
        tbl[9]  = '{0, 1, 2, 16'h0066, 0, 4, ov(3, 16'h00A5, 2, 16'h0055)};
        tbl[10] = '{0, 0, 2, 16'h0077, 0, 4, ov(3, 16'h00A5, 2, 16'h0055)};
        tbl[11] = '{0, 0, 5, 16'hFFFF, 0, 4, ov(3, 16'h00A5, 2, 16'h0055)};
        tbl[12] = '{1, 1, 5, 16'hBEEF, 0, 0, ov(-1, 0, -1, 0)};
        tbl[13] = '{0, 1, 5, 16'h0777, 1, 1, ov(5, 16'h0777, -1, 0)};
        tbl[14] = '{1, 0, 5, 16'h0000, 0, 0, ov(-1, 0, -1, 0)};
        tbl[15] = '{0, 0, 0, 16'h0000, 0, 0, ov(-1, 0, -1, 0)};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].sel, tbl[i].data);
            chk($sformatf("v%0d_ack", i), 128'(wr_ack), 128'(tbl[i].ack));
            chk($sformatf("v%0d_cnt", i), 128'(wr_count), 128'(tbl[i].cnt));
            chk($sformatf("v%0d_out", i), 128'(outs), 128'(tbl[i].o));
        end

        // Sweep: value N+1 into each index.
        acks = 0;
        for (int n = 0; n < 8; n++) begin
            step(0, 1, 3'(n), DW'(n + 1));
            if (wr_ack) acks++;
            step(0, 0, 3'(n), 16'hDEAD);
            if (wr_ack) acks++;
        end
        chk("sweep_acks", 128'(acks), 128'(8));
        chk("sweep_cnt", 128'(wr_count), 128'(8));
        for (int n = 0; n < 8; n++) begin
`ifdef RB_R0_ZERO_EN
            chk($sformatf("sweep_out%0d", n), 128'(outs[n]),
                128'((n == 0) ? 0 : n + 1));
`else
            chk($sformatf("sweep_out%0d", n), 128'(outs[n]), 128'(n + 1));
`endif
        end

        // Counter wrap.
        step(1, 0, 0, 0);
        for (int n = 0; n < 256; n++) begin
            step(0, 1, 3'(n % 8), DW'(n));
            if (n != 255) step(0, 0, 0, 0);
        end
        chk("wrap_256", 128'(wr_count), 128'(0));
        step(0, 0, 0, 0);
        step(0, 1, 1, 16'h0101);
        chk("wrap_257", 128'(wr_count), 128'(1));
        step(0, 0, 0, 0);

`ifdef RB_R0_ZERO_EN
        step(0, 1, 0, 16'hFFFF);
        chk("r0z_ack", 128'(wr_ack), 128'(1));
        chk("r0z_cnt", 128'(wr_count), 128'(2));
        chk("r0z_out0", 128'(o0), 128'(0));
        step(0, 0, 0, 0);
        chk("r0z_out0b", 128'(o0), 128'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
